frame_streamer: RTL and testbench

- Downstream consumer of the 84x48 frame memory that memory_updater writes.
- On start, reads the 48-bit column words and serialises one full screen as Nokia 5110 byte traffic for the SPI transmitter.
- Traffic per bank (6 banks, each 8 pixel rows): set-Y command, set-X command, then 84 data bytes.
- Byte output uses a valid/ready handshake towards the SPI transmitter.

---
 rtl/frame_streamer.sv | 182 ++++++++++++++++++
 tb/tb_frame_streamer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : frame_streamer
// Purpose  : Reads the 84x48 frame memory one column word at a time and
//            serialises a full screen as Nokia 5110 byte traffic. Each of the
//            6 banks is sent as set-Y command, set-X command, then 84 data
//            bytes, over a valid/ready handshake to the SPI transmitter.
// Ports    : clk, nrst      - clock, asynchronous active-low reset
//            start          - request one frame (sampled only when idle)
//            busy, done     - frame in progress / one-cycle completion pulse
//            mem_addr       - registered frame-memory read address
//            mem_out        - frame-memory read data (1-cycle sync RAM)
//            tx_data, tx_dc - byte and command(0)/data(1) flag
//            tx_valid       - byte valid; transfer on tx_valid && tx_ready
//            tx_ready       - transmitter ready
// Revision : 1.0 - initial release
// ============================================================================
module frame_streamer #(
   parameter int         COLUMNS   = 84,
   parameter int         BANKS     = 6,
   parameter logic [7:0] BASE_ADDR = 8'd0
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           mem_addr,
   input  logic [8*BANKS-1:0]   mem_out,
   output logic [7:0]           tx_data,
   output logic                 tx_dc,
   output logic                 tx_valid,
   input  logic                 tx_ready
);

   localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
   localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

   localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
   localparam logic [BW-1:0] BANK_LAST = BW'(BANKS - 1);
   localparam logic [7:0]    SET_Y     = 8'h40;   // OR'd with the bank number
   localparam logic [7:0]    SET_X     = 8'h80;   // always column 0

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CMD_Y   = 3'd1,
      S_CMD_X   = 3'd2,
      S_FETCH   = 3'd3,
      S_CAPTURE = 3'd4,
      S_SEND    = 3'd5
   } state_t;

   state_t        state, state_n;
   logic [BW-1:0] bank, bank_n;
   logic [CW-1:0] col, col_n;
   logic [7:0]    mem_addr_n;
   logic [7:0]    tx_data_n;
   logic          tx_dc_n, tx_valid_n;
   logic          busy_n, done_n;
   logic          xfer;
   logic [7:0]    bank_byte;

   assign xfer = tx_valid && tx_ready;

   // Byte of the current column word that belongs to the current bank.
   always_comb begin
      bank_byte = 8'd0;
      for (int b = 0; b < BANKS; b++) begin
         if (bank == BW'(b)) begin
            bank_byte = mem_out[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= S_IDLE;
         bank     <= '0;
         col      <= '0;
         mem_addr <= 8'd0;
         tx_data  <= 8'd0;
         tx_dc    <= 1'b0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         bank     <= bank_n;
         col      <= col_n;
         mem_addr <= mem_addr_n;
         tx_data  <= tx_data_n;
         tx_dc    <= tx_dc_n;
         tx_valid <= tx_valid_n;
         busy     <= busy_n;
         done     <= done_n;
      end
   end

   always_comb begin
      // Hold everything by default: a waiting state keeps its byte stable.
      state_n    = state;
      bank_n     = bank;
      col_n      = col;
      mem_addr_n = mem_addr;
      tx_data_n  = tx_data;
      tx_dc_n    = tx_dc;
      tx_valid_n = tx_valid;
      busy_n     = busy;
      done_n     = 1'b0;

      case (state)
         S_IDLE: begin
            if (start) begin
               bank_n     = '0;
               col_n      = '0;
               busy_n     = 1'b1;
               tx_data_n  = SET_Y;
               tx_dc_n    = 1'b0;
               tx_valid_n = 1'b1;
               state_n    = S_CMD_Y;
            end
         end

         S_CMD_Y: begin
            if (xfer) begin
               tx_data_n = SET_X;
               tx_dc_n   = 1'b0;
               state_n   = S_CMD_X;
            end
         end

         S_CMD_X: begin
            if (xfer) begin
               tx_valid_n = 1'b0;
               mem_addr_n = BASE_ADDR;
               state_n    = S_FETCH;
            end
         end

         // The RAM samples mem_addr on the edge leaving FETCH, so the word
         // is on mem_out during CAPTURE.
         S_FETCH: begin
            state_n = S_CAPTURE;
         end

         S_CAPTURE: begin
            tx_data_n  = bank_byte;
            tx_dc_n    = 1'b1;
            tx_valid_n = 1'b1;
            state_n    = S_SEND;
         end

         S_SEND: begin
            if (xfer) begin
               tx_valid_n = 1'b0;
               if (col != COL_LAST) begin
                  col_n      = col + CW'(1);
                  mem_addr_n = mem_addr + 8'd1;
                  state_n    = S_FETCH;
               end else if (bank != BANK_LAST) begin
                  bank_n     = bank + BW'(1);
                  col_n      = '0;
                  tx_data_n  = SET_Y | (8'(bank) + 8'd1);
                  tx_dc_n    = 1'b0;
                  tx_valid_n = 1'b1;
                  state_n    = S_CMD_Y;
               end else begin
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_IDLE;
               end
            end
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_streamer
// Purpose  : Self-checking bench for frame_streamer. A small RAM model feeds
//            mem_out; every expected byte of a frame is queued when the frame
//            is launched and popped as the DUT transfers bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_streamer;

   localparam int COLS    = 84;
   localparam int NBANK   = 6;
   localparam int FRAME_N = NBANK * (2 + COLS);

   logic        clk = 1'b0;
   logic        nrst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done;
   logic [7:0]  mem_addr;
   logic [47:0] mem_out = 48'd0;
   logic [7:0]  tx_data;
   logic        tx_dc, tx_valid;
   logic        tx_ready = 1'b1;

   always #5 clk = ~clk;

   frame_streamer #(
      .COLUMNS   (COLS),
      .BANKS     (NBANK),
      .BASE_ADDR (8'd0)
   ) dut (
      .clk      (clk),
      .nrst     (nrst),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .mem_addr (mem_addr),
      .mem_out  (mem_out),
      .tx_data  (tx_data),
      .tx_dc    (tx_dc),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready)
   );

   // Frame memory model: one-cycle synchronous read.
   logic [47:0] mem [0:COLS-1];
   always @(posedge clk) begin
      mem_out <= (int'(mem_addr) < COLS) ? mem[int'(mem_addr)] : 48'd0;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard: {dc, byte}
   logic [8:0] exp_q [$];

   function automatic void push_frame();
      for (int b = 0; b < NBANK; b++) begin
         exp_q.push_back({1'b0, 8'h40 | 8'(b)});
         exp_q.push_back({1'b0, 8'h80});
         for (int x = 0; x < COLS; x++) begin
            exp_q.push_back({1'b1, mem[x][8*b +: 8]});
         end
      end
   endfunction

   int          edges = 0;
   int          n_seen = 0;
   int          done_cnt = 0;
   int          done_edge = 0;
   logic        prev_hold = 1'b0;
   logic [8:0]  prev_byte = 9'd0;
   logic [8:0]  e_byte;

   logic        addr_mon = 1'b0;
   logic [7:0]  prev_addr = 8'd0;
   int          last_chg = -1;
   int          inc_cnt = 0, gap_bad = 0, bad_steps = 0, addr_max = 0;

   always @(posedge clk) edges++;

   // Output monitor, sampled on the falling edge: a valid&&ready seen here
   // is the transfer completed by the following rising edge.
   always @(negedge clk) begin
      if (nrst) begin
         if (prev_hold)
            check("hold", {23'd0, tx_valid, tx_dc, tx_data}, {23'd0, 1'b1, prev_byte});
         prev_hold = tx_valid && !tx_ready;
         prev_byte = {tx_dc, tx_data};
         if (tx_valid && tx_ready) begin
            n_seen++;
            if (exp_q.size() == 0) begin
               check("extra_xfer", 32'd1, 32'd0);
            end else begin
               e_byte = exp_q.pop_front();
               check($sformatf("xfer%0d", n_seen), {23'd0, tx_dc, tx_data}, {23'd0, e_byte});
            end
         end
         if (done) begin
            done_cnt++;
            done_edge = edges;
         end
         if (addr_mon) begin
            if (mem_addr != prev_addr) begin
               if (mem_addr == prev_addr + 8'd1) begin
                  inc_cnt++;
                  if (last_chg >= 0 && edges - last_chg != 3) gap_bad++;
               end else if (mem_addr != 8'd0) begin
                  bad_steps++;
               end
               last_chg = edges;
            end
            if (int'(mem_addr) > addr_max) addr_max = int'(mem_addr);
         end
         prev_addr = mem_addr;
      end else begin
         prev_hold = 1'b0;
      end
   end

   int s_edge;

   task automatic start_frame();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      s_edge = edges;
   endtask

   task automatic wait_seen(input int target);
      int k;
      for (k = 0; k < 5000; k++) begin
         @(negedge clk); #1;
         if (n_seen >= target) break;
      end
      if (k == 5000) check("seen_timeout", n_seen, target);
   endtask

   task automatic wait_done(input int d0);
      int k;
      for (k = 0; k < 5000; k++) begin
         @(negedge clk); #1;
         if (done_cnt > d0) break;
      end
      if (k == 5000) check("done_timeout", done_cnt, d0 + 1);
   endtask

   task automatic stall_after(input int target);
      wait_seen(target);
      @(posedge clk); #1 tx_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 tx_ready = 1'b1;
   endtask

   // Runs a frame already queued and started; checks count, pulse and queue.
   task automatic finish_frame(input int f0, input int d0);
      wait_done(d0);
      @(negedge clk); #1;
      check("frame_xfers", n_seen - f0, FRAME_N);
      check("done_pulses", done_cnt - d0, 1);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after", {31'd0, busy}, 32'd0);
   endtask

   int f0, d0, k;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Asynchronous reset before any clock edge.
      #2 nrst = 1'b0;
      #1;
      check("rst_busy",     {31'd0, busy},     32'd0);
      check("rst_done",     {31'd0, done},     32'd0);
      check("rst_addr",     {24'd0, mem_addr}, 32'd0);
      check("rst_data",     {24'd0, tx_data},  32'd0);
      check("rst_dc",       {31'd0, tx_dc},    32'd0);
      check("rst_valid",    {31'd0, tx_valid}, 32'd0);
      repeat (2) @(negedge clk);
      #2 nrst = 1'b1;

      // Frame A: ramp pattern, ready high, timing and address trace.
      for (int x = 0; x < COLS; x++) mem[x] = 48'h050403020100 + 48'(x);
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      addr_mon = 1'b1;
      start_frame();
      check("first_valid", {31'd0, tx_valid}, 32'd1);
      check("first_busy",  {31'd0, busy},     32'd1);
      check("first_byte",  {24'd0, tx_data},  32'h40);
      wait_done(d0);
      check("done_cycle", done_edge - s_edge, 1524);
      addr_mon = 1'b0;
      check("addr_incs",  inc_cnt,   NBANK * (COLS - 1));
      check("addr_gaps",  gap_bad,   0);
      check("addr_steps", bad_steps, 0);
      check("addr_max",   addr_max,  COLS - 1);
      @(negedge clk); #1;
      check("frameA_xfers", n_seen - f0, FRAME_N);
      check("frameA_done",  done_cnt - d0, 1);

      // Frame B: single non-zero word.
      for (int x = 0; x < COLS; x++) mem[x] = 48'd0;
      mem[0] = 48'hAABBCCDDEEFF;
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      finish_frame(f0, d0);

      // Frame C: back-pressure during CMD_X of bank 0 and SEND of bank 2 col 40.
      for (int x = 0; x < COLS; x++) mem[x] = {8'(x), 8'(x ^ 8'h5A), 8'(x + 7), 8'(~x), 8'(x * 3), 8'(x + 100)};
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      stall_after(f0 + 1);
      stall_after(f0 + 2 * (2 + COLS) + 2 + 40);
      finish_frame(f0, d0);

      // Frame D: a second start mid-frame is ignored.
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      wait_seen(f0 + 200);
      start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
      finish_frame(f0, d0);

      // Frame E: start held through the done cycle -> back-to-back frames.
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      wait_seen(f0 + FRAME_N);
      start = 1'b1;
      push_frame();
      wait_done(d0);
      k = done_edge;
      @(posedge clk); #1 start = 1'b0;
      check("b2b_valid", {31'd0, tx_valid}, 32'd1);
      check("b2b_busy",  {31'd0, busy},     32'd1);
      check("b2b_byte",  {24'd0, tx_data},  32'h40);
      wait_done(d0 + 1);
      check("b2b_spacing", done_edge - k, 1525);
      @(negedge clk); #1;
      check("b2b_xfers", n_seen - f0, 2 * FRAME_N);
      check("b2b_empty", exp_q.size(), 0);

      // Frame F: asynchronous reset while holding in SEND of bank 3.
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      wait_seen(f0 + 3 * (2 + COLS) + 10);
      @(posedge clk); #1 tx_ready = 1'b0;
      for (k = 0; k < 20; k++) begin
         @(negedge clk); #1;
         if (tx_valid && tx_dc) break;
      end
      check("reached_send", {31'd0, tx_valid && tx_dc}, 32'd1);
      #2 nrst = 1'b0;
      #1;
      check("abort_valid", {31'd0, tx_valid}, 32'd0);
      check("abort_busy",  {31'd0, busy},     32'd0);
      check("abort_done",  {31'd0, done},     32'd0);
      check("abort_addr",  {24'd0, mem_addr}, 32'd0);
      check("abort_data",  {24'd0, tx_data},  32'd0);
      check("abort_dc",    {31'd0, tx_dc},    32'd0);
      exp_q.delete();
      tx_ready = 1'b1;
      repeat (3) @(negedge clk);
      #2 nrst = 1'b1;
      check("abort_no_done", done_cnt - d0, 0);

      // Fresh frame after the abort.
      push_frame();
      f0 = n_seen; d0 = done_cnt;
      start_frame();
      finish_frame(f0, d0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
